// File: rtl/jtcontra_prio_colmix.sv
// jtcontra_prio_colmix
// Multi-layer colour mixer. Resolves priority and transparency among LAYERS
// pixel indices on each pxl_cen. Fetches the winner's 16-bit palette word as
// two bytes from a CPU-writable palette RAM. Outputs blanked RGB.
//
// Optional feature: define JTCONTRA_COLMIX_SHADOW_EN to treat palette word
// bit 15 as a shadow flag. When the flag is set, each component is halved
// before it enters the blanking pipeline. Without the macro, bit 15 is ignored.
//
// Ports
//   clk, rst_n           system/CPU clock, asynchronous active-low reset
//   pxl_cen              pixel strobe (pixels at least 4 clk apart)
//   LHBL, LVBL           active-low blanking in
//   LHBL_dly, LVBL_dly   blanking delayed by BLANK_DLY pxl_cen
//   pal_cs, cpu_rnw,     CPU palette access; cpu_addr = {layer, index, half},
//   cpu_cen, cpu_addr,   where half = 0 is the low byte of the word
//   cpu_dout
//   pal_dout             CPU read data, one clk after the read cycle
//   prio_mode            0: layer 0 first, 1: reversed, 2: top layer wins
//                        when opaque, 3: layer 0 only if its index MSB is set
//   gfx_pxl              layer k at [k*PXLW +: PXLW]; colour bits [3:0] == 0
//                        means the pixel is transparent
//   red, green, blue     colour out, zero while blanked
//   fsm_state            fetch FSM state (IDLE=0, RD_LO=1, RD_HI=2, DONE=3)
//
// Timing: a pixel sampled at pxl_cen n reaches RGB after pxl_cen n+1+BLANK_DLY.

module jtcontra_prio_colmix #(
    parameter  int LAYERS    = 2,
    parameter  int PXLW      = 7,
    parameter  int BPC       = 5,
    parameter  int BLANK_DLY = 3,
    localparam int LW        = (LAYERS > 2) ? 2 : 1,
    localparam int AW        = LW + PXLW + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly,
    input  logic                   pal_cs,
    input  logic                   cpu_rnw,
    input  logic                   cpu_cen,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             pal_dout,
    input  logic [1:0]             prio_mode,
    input  logic [LAYERS*PXLW-1:0] gfx_pxl,
    output logic [BPC-1:0]         red,
    output logic [BPC-1:0]         green,
    output logic [BPC-1:0]         blue,
    output logic [1:0]             fsm_state
);

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, DONE} state_t;

    localparam int CW = 3 * BPC;

    // ---------------- palette RAM ----------------
    logic [7:0]    pal_ram [0:(2**AW)-1];
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_q;
    logic          cpu_we;
    logic          cpu_rd;

    assign cpu_we = pal_cs & cpu_cen & ~cpu_rnw;
    assign cpu_rd = pal_cs & cpu_cen &  cpu_rnw;

    // The video read samples the array before the write of the same edge.
    // So a colliding read returns the old byte.
    always_ff @(posedge clk) begin
        if (cpu_we) pal_ram[cpu_addr] <= cpu_dout;
        vid_q <= pal_ram[vid_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_dout <= 8'd0;
        end else if (cpu_rd) begin
            pal_dout <= pal_ram[cpu_addr];
        end
    end

    // ---------------- priority resolution ----------------
    logic [LAYERS-1:0] opaque;
    logic [LW-1:0]     win_layer;
    logic [PXLW-1:0]   win_idx;

    always_comb begin
        opaque = '0;
        for (int k = 0; k < LAYERS; k++) opaque[k] = |gfx_pxl[k*PXLW +: 4];
        if (prio_mode == 2'd3) opaque[0] = opaque[0] & gfx_pxl[PXLW-1];
    end

    // Loops overwrite the choice, so the last opaque layer visited wins.
    // With no opaque layer, the result is layer 0 with index 0 (the backdrop entry).
    always_comb begin
        win_layer = '0;
        if (prio_mode == 2'd1) begin
            for (int k = 0; k < LAYERS; k++)
                if (opaque[k]) win_layer = LW'(k);
        end else begin
            for (int k = LAYERS - 1; k >= 0; k--)
                if (opaque[k]) win_layer = LW'(k);
            if (prio_mode == 2'd2 && opaque[LAYERS-1]) win_layer = LW'(LAYERS - 1);
        end
        win_idx = '0;
        for (int k = 0; k < LAYERS; k++)
            if (opaque[k] && win_layer == LW'(k)) win_idx = gfx_pxl[k*PXLW +: PXLW];
    end

    // ---------------- fetch FSM ----------------
    state_t          st;
    logic [LW-1:0]   lat_layer;
    logic [PXLW-1:0] lat_idx;
    logic [7:0]      lo_byte;
    logic [CW-1:0]   col_latch;
    logic [15:0]     vid_word;
    logic            unused_word;
`ifdef JTCONTRA_COLMIX_SHADOW_EN
    logic            col_shade;
`endif

    // RAM data lags the address by one clk. The low byte is presented in
    // RD_LO and is available in RD_HI. The high byte is presented in RD_HI
    // and is available in DONE.
    assign vid_addr    = {lat_layer, lat_idx, st != RD_LO};
    assign vid_word    = {vid_q, lo_byte};
    assign unused_word = &{1'b0, vid_word};
    assign fsm_state   = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            lat_layer <= '0;
            lat_idx   <= '0;
            lo_byte   <= 8'd0;
            col_latch <= '0;
`ifdef JTCONTRA_COLMIX_SHADOW_EN
            col_shade <= 1'b0;
`endif
        end else if (pxl_cen) begin
            // A strobe in any state restarts the fetch. If the previous fetch
            // is unfinished, it is dropped and the colour latch keeps its value.
            lat_layer <= win_layer;
            lat_idx   <= win_idx;
            st        <= RD_LO;
        end else begin
            case (st)
                RD_LO: st <= RD_HI;
                RD_HI: begin
                    lo_byte <= vid_q;
                    st      <= DONE;
                end
                DONE: begin
                    col_latch <= vid_word[CW-1:0];
`ifdef JTCONTRA_COLMIX_SHADOW_EN
                    col_shade <= vid_word[15];
`endif
                    st        <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    // ---------------- shadow and blanking pipeline ----------------
    logic [CW-1:0]        col_in;
    logic [CW-1:0]        col_pipe [0:BLANK_DLY-1];
    logic [CW-1:0]        rgb_q;
    logic [BLANK_DLY-1:0] sh_h;
    logic [BLANK_DLY-1:0] sh_v;

    always_comb begin
        col_in = col_latch;
`ifdef JTCONTRA_COLMIX_SHADOW_EN
        if (col_shade)
            col_in = {1'b0, col_latch[3*BPC-1:2*BPC+1],
                      1'b0, col_latch[2*BPC-1:BPC+1],
                      1'b0, col_latch[BPC-1:1]};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BLANK_DLY; i++) col_pipe[i] <= '0;
            rgb_q <= '0;
            sh_h  <= '0;
            sh_v  <= '0;
        end else if (pxl_cen) begin
            col_pipe[0] <= col_in;
            for (int i = 1; i < BLANK_DLY; i++) col_pipe[i] <= col_pipe[i-1];
            rgb_q   <= col_pipe[BLANK_DLY-1];
            sh_h[0] <= LHBL;
            sh_v[0] <= LVBL;
            for (int i = 1; i < BLANK_DLY; i++) begin
                sh_h[i] <= sh_h[i-1];
                sh_v[i] <= sh_v[i-1];
            end
        end
    end

    assign LHBL_dly = sh_h[BLANK_DLY-1];
    assign LVBL_dly = sh_v[BLANK_DLY-1];

    assign red   = (LHBL_dly & LVBL_dly) ? rgb_q[BPC-1:0]       : '0;
    assign green = (LHBL_dly & LVBL_dly) ? rgb_q[2*BPC-1:BPC]   : '0;
    assign blue  = (LHBL_dly & LVBL_dly) ? rgb_q[3*BPC-1:2*BPC] : '0;

endmodule

// File: tb/tb_jtcontra_prio_colmix.sv
// Bench for jtcontra_prio_colmix (LAYERS=2, PXLW=7, BPC=5, BLANK_DLY=3).
// A model of the palette and priority rules predicts every output cycle.
// Directed checks with literal values cover reset, palette, priority, backdrop,
// blanking, spacing violation and shadow.

module tb_jtcontra_prio_colmix;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pxl_cen;
  logic        LHBL, LVBL;
  logic        LHBL_dly, LVBL_dly;
  logic        pal_cs, cpu_rnw, cpu_cen;
  logic [8:0]  cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  pal_dout;
  logic [1:0]  prio_mode;
  logic [13:0] gfx_pxl;
  logic [4:0]  red, green, blue;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  jtcontra_prio_colmix #(.LAYERS(2), .PXLW(7), .BPC(5), .BLANK_DLY(D)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .pal_cs(pal_cs), .cpu_rnw(cpu_rnw),
    .cpu_cen(cpu_cen), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout),
    .prio_mode(prio_mode), .gfx_pxl(gfx_pxl), .red(red), .green(green), .blue(blue),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [7:0] pal_m [512];

  // Returns {layer, index}: layers are tried in priority order, first eligible wins.
  function automatic logic [7:0] model_base(input logic [6:0] p0, input logic [6:0] p1,
                                            input logic [1:0] m);
    logic [6:0] px [2];
    int order [2];
    px[0] = p0;
    px[1] = p1;
    // With two layers, mode 2 (top layer first, then layer 0) equals mode 1.
    if (m == 2'd0 || m == 2'd3) begin order[0] = 0; order[1] = 1; end
    else begin order[0] = 1; order[1] = 0; end
    for (int n = 0; n < 2; n++) begin
      int i;
      bit ok;
      i = order[n];
      ok = (px[i][3:0] != 4'd0);
      if (m == 2'd3 && i == 0 && !px[0][6]) ok = 1'b0;
      if (ok) return {1'(i), px[i]};
    end
    return 8'h00;
  endfunction

  function automatic logic [14:0] model_colour(input logic [7:0] base);
    logic [15:0] w;
    logic [4:0] r, g, b;
    w = {pal_m[{base, 1'b1}], pal_m[{base, 1'b0}]};
    r = w[4:0];
    g = w[9:5];
    b = w[14:10];
`ifdef JTCONTRA_COLMIX_SHADOW_EN
    if (w[15]) begin r = r / 2; g = g / 2; b = b / 2; end
`endif
    return {b, g, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  // lat_hist[k] is the completed colour held before strobe k. Blanking value
  // sampled at strobe j shows on *_dly after strobe j+D-1. The colour held
  // before strobe k shows on RGB after strobe k+D.
  logic [14:0] lat_hist [4096];
  logic        hb_hist  [4096];
  logic        vb_hist  [4096];
  logic [16:0] exp_out;
  logic [14:0] lat_cur, pend;
  int k, cyc, last_cyc;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0; cyc = 0; last_cyc = 0; lat_cur = '0; pend = '0; exp_out = '0;
      end else begin
        logic hb, vb;
        logic [14:0] col;
        cyc++;
        if (pal_cs && cpu_cen && !cpu_rnw) pal_m[cpu_addr] = cpu_dout;
        if (pxl_cen && k < 4095) begin
          k++;
          if (k > 1 && (cyc - last_cyc) >= 4) lat_cur = pend;
          lat_hist[k] = lat_cur;
          hb_hist[k]  = LHBL;
          vb_hist[k]  = LVBL;
          pend     = model_colour(model_base(gfx_pxl[6:0], gfx_pxl[13:7], prio_mode));
          last_cyc = cyc;
          hb  = (k - D + 1 >= 1) ? hb_hist[k-D+1] : 1'b0;
          vb  = (k - D + 1 >= 1) ? vb_hist[k-D+1] : 1'b0;
          col = (k - D >= 1) ? lat_hist[k-D] : 15'd0;
          exp_out = {hb, vb, (hb & vb) ? col : 15'd0};
        end
        #1;
        n_checks++;
        if ({LHBL_dly, LVBL_dly, blue, green, red} !== exp_out) begin
          n_errors++;
          $display("FAIL cycle_out at strobe %0d: got %h expected %h", k,
                   {LHBL_dly, LVBL_dly, blue, green, red}, exp_out);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
    pal_cs = 1'b1; cpu_cen = 1'b1; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
    @(posedge clk); #1;
    pal_cs = 1'b0; cpu_cen = 1'b0; cpu_rnw = 1'b1;
  endtask

  task automatic cpu_read_chk(input logic [8:0] a, input logic [7:0] lit);
    pal_cs = 1'b1; cpu_cen = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
    @(posedge clk); #1;
    pal_cs = 1'b0; cpu_cen = 1'b0;
    chk("pal_dout_lit", 32'(pal_dout), 32'(lit));
    chk("pal_dout_model", 32'(pal_dout), 32'(pal_m[a]));
  endtask

  task automatic pix(input logic [6:0] p0, input logic [6:0] p1, input logic [1:0] m,
                     input logic hb, input logic vb, input int gap);
    gfx_pxl = {p1, p0}; prio_mode = m; LHBL = hb; LVBL = vb; pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic flush();
    repeat (D + 1) pix(7'h00, 7'h00, 2'd0, 1'b1, 1'b1, 4);
  endtask

  task automatic show_rgb(input logic [6:0] p0, input logic [6:0] p1, input logic [1:0] m,
                          input string name, input logic [14:0] lit);
    pix(p0, p1, m, 1'b1, 1'b1, 4);
    flush();
    chk(name, 32'({blue, green, red}), 32'(lit));
  endtask

  // ---------------- directed vectors ----------------
  logic [6:0] t0 [12] = '{7'h00, 7'h01, 7'h45, 7'h05, 7'h7F, 7'h30,
                          7'h41, 7'h12, 7'h09, 7'h40, 7'h2C, 7'h03};
  logic [6:0] t1 [12] = '{7'h13, 7'h00, 7'h22, 7'h10, 7'h01, 7'h3A,
                          7'h00, 7'h0F, 7'h50, 7'h11, 7'h07, 7'h66};

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0; cpu_addr = '0; cpu_dout = '0;
    prio_mode = '0; gfx_pxl = '0;
    for (int i = 0; i < 512; i++) pal_m[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset values
    chk("reset_rgb", 32'({blue, green, red}), 32'd0);
    chk("reset_blank", 32'({LHBL_dly, LVBL_dly}), 32'd0);
    chk("reset_pal_dout", 32'(pal_dout), 32'd0);
    chk("reset_fsm", 32'(fsm_state), 32'd0);

    // model pins
    chk("model_mode0", 32'(model_base(7'h05, 7'h13, 2'd0)), 32'h05);
    chk("model_mode1", 32'(model_base(7'h05, 7'h13, 2'd1)), 32'h93);
    chk("model_mode3", 32'(model_base(7'h05, 7'h13, 2'd3)), 32'h93);
    chk("model_mode3_msb", 32'(model_base(7'h45, 7'h13, 2'd3)), 32'h45);
    chk("model_backdrop", 32'(model_base(7'h10, 7'h20, 2'd1)), 32'h00);

    // fill the palette with a known pattern
    for (int a = 0; a < 512; a++) cpu_write(9'(a), 8'((a * 37 + 11) & 8'hFF));

    // palette: word 0x001F at layer 0 index 1
    cpu_write(9'h002, 8'h1F);
    cpu_write(9'h003, 8'h00);
    cpu_read_chk(9'h002, 8'h1F);
    show_rgb(7'h01, 7'h00, 2'd0, "palette_red31", {5'd0, 5'd0, 5'd31});

    // priority: layer0 idx 0x05 -> blue 31, layer1 idx 0x13 -> green 31
    cpu_write(9'h00A, 8'h00);
    cpu_write(9'h00B, 8'h7C);
    cpu_write(9'h126, 8'hE0);
    cpu_write(9'h127, 8'h03);
    show_rgb(7'h05, 7'h13, 2'd0, "prio_mode0", {5'd31, 5'd0, 5'd0});
    show_rgb(7'h05, 7'h13, 2'd1, "prio_mode1", {5'd0, 5'd31, 5'd0});
    show_rgb(7'h05, 7'h13, 2'd2, "prio_mode2", {5'd0, 5'd31, 5'd0});
    show_rgb(7'h05, 7'h13, 2'd3, "prio_mode3", {5'd0, 5'd31, 5'd0});
    show_rgb(7'h05, 7'h00, 2'd1, "prio_mode1_only0", {5'd31, 5'd0, 5'd0});

    // backdrop: every layer transparent
    cpu_write(9'h000, 8'h15);
    cpu_write(9'h001, 8'h00);
    show_rgb(7'h10, 7'h20, 2'd0, "backdrop", {5'd0, 5'd0, 5'd21});

    // blanking: one strobe with LHBL low, then with LVBL low
    repeat (D + 2) pix(7'h01, 7'h00, 2'd0, 1'b1, 1'b1, 4);
    pix(7'h01, 7'h00, 2'd0, 1'b0, 1'b1, 4);
    for (int i = 1; i <= D; i++) begin
      pix(7'h01, 7'h00, 2'd0, 1'b1, 1'b1, 4);
      chk("lhbl_dly", 32'(LHBL_dly), (i == D - 1) ? 32'd0 : 32'd1);
      chk("lhbl_red", 32'(red), (i == D - 1) ? 32'd0 : 32'd31);
    end
    pix(7'h01, 7'h00, 2'd0, 1'b1, 1'b0, 4);
    for (int i = 1; i <= D; i++) begin
      pix(7'h01, 7'h00, 2'd0, 1'b1, 1'b1, 4);
      chk("lvbl_dly", 32'(LVBL_dly), (i == D - 1) ? 32'd0 : 32'd1);
    end

    // spacing violation: strobes 2 clk apart never complete a fetch
    pix(7'h05, 7'h13, 2'd1, 1'b1, 1'b1, 4);
    repeat (D + 4) pix(7'h05, 7'h13, 2'd0, 1'b1, 1'b1, 2);
    chk("spacing_repeat", 32'({blue, green, red}), 32'({5'd0, 5'd31, 5'd0}));
    show_rgb(7'h05, 7'h13, 2'd0, "spacing_recover", {5'd31, 5'd0, 5'd0});

    // shadow flag in bit 15
    cpu_write(9'h003, 8'h80);
`ifdef JTCONTRA_COLMIX_SHADOW_EN
    show_rgb(7'h01, 7'h00, 2'd0, "shadow_word", {5'd0, 5'd0, 5'd15});
`else
    show_rgb(7'h01, 7'h00, 2'd0, "shadow_word", {5'd0, 5'd0, 5'd31});
`endif

    // directed table, mixed modes and spacing, model-checked
    for (int i = 0; i < 12; i++) pix(t0[i], t1[i], 2'(i % 4), 1'b1, 1'b1, 4 + (i % 3));
    flush();

    // asynchronous reset during a fetch
    cpu_read_chk(9'h003, 8'h80);
    pix(7'h01, 7'h00, 2'd0, 1'b1, 1'b1, 4);
    flush();
    gfx_pxl = {7'h13, 7'h05}; prio_mode = 2'd0; pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    chk("fsm_rd_lo", 32'(fsm_state), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", 32'({blue, green, red}), 32'd0);
    chk("async_rst_blank", 32'({LHBL_dly, LVBL_dly}), 32'd0);
    chk("async_rst_pal_dout", 32'(pal_dout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_fsm", 32'(fsm_state), 32'd0);

    // palette contents survive reset
`ifdef JTCONTRA_COLMIX_SHADOW_EN
    show_rgb(7'h01, 7'h00, 2'd0, "post_rst_palette", {5'd0, 5'd0, 5'd15});
`else
    show_rgb(7'h01, 7'h00, 2'd0, "post_rst_palette", {5'd0, 5'd0, 5'd31});
`endif

    repeat (4) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
